// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline-buffer types: fetch-queue entry layout and front-end state encoding.
// The entry struct is sized for the default fetch_queue configuration (PC_W=9, INS_W=32).
package Pipe_Buf_Reg_PKG;

    localparam int FQ_PC_W  = 9;
    localparam int FQ_INS_W = 32;

    typedef struct packed {
        logic [FQ_PC_W-1:0]  pc;
        logic [FQ_INS_W-1:0] instr;
    } fq_entry_t;

    typedef enum logic [0:0] {
        RESET = 1'b0,
        RUN   = 1'b1
    } fq_state_e;

endpackage

// File: rtl/fq_fifo.sv
// Parametrised circular FIFO with pointers, count and a synchronous flush.
module fq_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // Qualify requests: pop needs data, push needs room or a same-cycle pop.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (!flush) begin
            pop_ok_s  = pop && !empty;
            push_ok_s = push && (!full || pop_ok_s);
        end else begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    fq_fifo_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop_ok_s),
        .full    (full)
    );

endmodule

// File: rtl/fq_fifo_chk.sv
// Checker for fq_fifo: a push into a full queue is only legal together with a pop.
module fq_fifo_chk (
    input logic clk,
    input logic reset_n,
    input logic push,
    input logic pop,
    input logic full
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, request issue, redirect kill and prefetch queue.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue response bypass to if_*).
module fetch_queue
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int               PC_W     = 9,
    parameter int               INS_W    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}},
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INS_W-1:0]  imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [INS_W-1:0]  if_instr,
    input  logic              if_ready,
    output logic [CW-1:0]     occupancy
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    fq_state_e       state_r;
    fq_state_e       next_state_s;
    logic [PC_W-1:0] fetch_pc_r;
    logic [PC_W-1:0] issued_pc_r;
    logic            inflight_r;
    logic            kill_r;
    logic            issue_s;
    logic [CW:0]     outstanding_s;
    logic            resp_s;
    logic            bypass_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic            empty_s;
    logic            full_s;
    logic [CW-1:0]   count_s;
    entry_t          head_s;
    entry_t          wentry_s;
    logic            unused_s;

    assign unused_s  = ^{redirect_pc[1:0], full_s};
    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_r;
    assign occupancy = count_s;
    assign wentry_s  = '{pc: issued_pc_r, instr: imem_rdata};

    // Front-end state: one idle cycle after reset, then run forever.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= RESET;
        else          state_r <= next_state_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RESET:   next_state_s = RUN;
            RUN:     next_state_s = RUN;
            default: next_state_s = RESET;
        endcase
    end

    // Issue only while entries already held plus the one in flight leave room.
    always_comb begin
        outstanding_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
        if ((state_r == RUN) && !halt && !redirect && (outstanding_s < (CW+1)'(DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // PC, in-flight tracking and kill; a redirect overrides any increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r  <= RESET_PC;
            issued_pc_r <= {PC_W{1'b0}};
            inflight_r  <= 1'b0;
            kill_r      <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            kill_r     <= redirect && inflight_r;
            if (redirect) begin
                fetch_pc_r <= {redirect_pc[PC_W-1:2], 2'b00};
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + PC_W'(4);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (issue_s) issued_pc_r <= fetch_pc_r;
        end
    end

    // A response arriving in a redirect cycle belongs to the old path.
    always_comb begin
        resp_s = inflight_r && !kill_r && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s = resp_s && empty_s;
`else
        bypass_s = 1'b0;
`endif
        fifo_pop_s  = !empty_s && if_ready && !redirect;
        fifo_push_s = resp_s && !(bypass_s && if_ready);
    end

    // Decode-side view: queue head, else the bypassed response, else zeros.
    always_comb begin
        if_valid = 1'b0;
        if_pc    = {PC_W{1'b0}};
        if_instr = {INS_W{1'b0}};
        if (!empty_s) begin
            if_valid = 1'b1;
            if_pc    = head_s.pc;
            if_instr = head_s.instr;
        end else if (bypass_s) begin
            if_valid = 1'b1;
            if_pc    = issued_pc_r;
            if_instr = imem_rdata;
        end else begin
            if_valid = 1'b0;
        end
    end

    fq_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push_s),
        .pop     (fifo_pop_s),
        .flush   (redirect),
        .wdata   (wentry_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s),
        .head    (head_s)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, fill/stall, redirects, PC wrap, halt.
module tb_fetch_queue;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             halt;
    logic             if_ready;

    logic             req_a, req_b;
    logic [PC_W-1:0]  addr_a, addr_b;
    logic [INS_W-1:0] rdata_a, rdata_b;
    logic             valid_a, valid_b;
    logic [PC_W-1:0]  pc_a, pc_b;
    logic [INS_W-1:0] instr_a, instr_b;
    logic [OW-1:0]    occ_a, occ_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return {11'd0, a, 12'h013};
    endfunction

    // One-cycle-latency instruction memories.
    always @(posedge clk) begin
        rdata_a <= instr_of(addr_a);
        rdata_b <= instr_of(addr_b);
    end

    fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(9'h000)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .if_valid(valid_a),
        .if_pc(pc_a), .if_instr(instr_a), .if_ready(if_ready), .occupancy(occ_a));

    fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(9'h1FC)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .if_valid(valid_b),
        .if_pc(pc_b), .if_instr(instr_b), .if_ready(if_ready), .occupancy(occ_b));

    task automatic cyc();
        @(negedge clk);
    endtask

    // Leaves the bench #1 after the first post-release edge window, i.e. inside cycle 0.
    task automatic do_reset(input logic rdy);
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 9'h000; halt = 1'b0; if_ready = rdy;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 9'h000; halt = 1'b0; if_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_a); end
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", req_a); end
        checks++; if (occ_a !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d exp 0", occ_a); end
        checks++; if (pc_a !== 9'h000) begin errors++; $display("FAIL rst_pc: got %h exp 0", pc_a); end
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr_a); end
    endtask

    task automatic test_first_fetch();
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            if (k == 0) begin
                checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL ff_req_c0: got %b exp 0", req_a); end
            end
            if (k >= 1 && k <= 3) begin
                checks++; if (req_a !== 1'b1 || addr_a !== 9'((k - 1) * 4))
                    begin errors++; $display("FAIL ff_addr_c%0d: got req=%b addr=%h exp req=1 addr=%h", k, req_a, addr_a, 9'((k - 1) * 4)); end
            end
            if (k < LAT) begin
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ff_novalid_c%0d: got %b exp 0", k, valid_a); end
            end
            if (k == LAT) begin
                checks++; if (valid_a !== 1'b1 || pc_a !== 9'h000 || instr_a !== 32'h00000013)
                    begin errors++; $display("FAIL ff_first: got v=%b pc=%h i=%h exp v=1 pc=000 i=00000013", valid_a, pc_a, instr_a); end
            end
            if (k == LAT + 1) begin
                checks++; if (valid_a !== 1'b1 || pc_a !== 9'h004)
                    begin errors++; $display("FAIL ff_second: got v=%b pc=%h exp v=1 pc=004", valid_a, pc_a); end
            end
        end
    endtask

    task automatic test_stall_fill();
        int reqs = 0;
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(); #1;
            if (req_a) reqs++;
        end
        checks++; if (occ_a !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d exp 4", occ_a); end
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL fill_req: got %b exp 0", req_a); end
        checks++; if (valid_a !== 1'b1 || pc_a !== 9'h000) begin errors++; $display("FAIL fill_head: got v=%b pc=%h exp v=1 pc=000", valid_a, pc_a); end
        checks++; if (reqs != 4) begin errors++; $display("FAIL fill_reqs: got %0d exp 4", reqs); end
        reset_n = 1'b0; #1;
        checks++; if (occ_a !== 3'd0 || valid_a !== 1'b0) begin errors++; $display("FAIL async_rst: got occ=%0d v=%b exp occ=0 v=0", occ_a, valid_a); end
    endtask

    task automatic test_redirect_flush();
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) cyc();
        cyc();
        checks++; if (occ_a !== 3'd3) begin errors++; $display("FAIL rd_pre_occ: got %0d exp 3", occ_a); end
        redirect = 1'b1; redirect_pc = 9'h041; #1;
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL rd_req_n: got %b exp 0", req_a); end
        cyc(); redirect = 1'b0; if_ready = 1'b1; #1;
        checks++; if (occ_a !== 3'd0 || valid_a !== 1'b0) begin errors++; $display("FAIL rd_flush: got occ=%0d v=%b exp occ=0 v=0", occ_a, valid_a); end
        checks++; if (req_a !== 1'b1 || addr_a !== 9'h040) begin errors++; $display("FAIL rd_target: got req=%b addr=%h exp req=1 addr=040", req_a, addr_a); end
        for (int k = 7; k <= 8; k++) begin
            cyc(); #1;
            if (k < 5 + LAT) begin
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rd_novalid_c%0d: got %b exp 0", k, valid_a); end
            end
            if (k == 5 + LAT) begin
                checks++; if (valid_a !== 1'b1 || pc_a !== 9'h040 || instr_a !== 32'h00040013)
                    begin errors++; $display("FAIL rd_first: got v=%b pc=%h i=%h exp v=1 pc=040 i=00040013", valid_a, pc_a, instr_a); end
            end
        end
    endtask

    task automatic test_back_to_back_redirect();
        logic saw40 = 1'b0;
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) cyc();
        cyc(); redirect = 1'b1; redirect_pc = 9'h040; #1;
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL b2b_req1: got %b exp 0", req_a); end
        cyc(); redirect_pc = 9'h080; #1;
        checks++; if (req_a !== 1'b0 || occ_a !== 3'd0 || valid_a !== 1'b0)
            begin errors++; $display("FAIL b2b_mid: got req=%b occ=%0d v=%b exp 0/0/0", req_a, occ_a, valid_a); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (req_a !== 1'b1 || addr_a !== 9'h080) begin errors++; $display("FAIL b2b_target: got req=%b addr=%h exp req=1 addr=080", req_a, addr_a); end
        for (int k = 7; k < 13; k++) begin
            if (k > 7) begin cyc(); #1; end
            if ((valid_a && pc_a == 9'h040) || (req_a && addr_a == 9'h040)) saw40 = 1'b1;
            if (k == 6 + LAT) begin
                checks++; if (valid_a !== 1'b1 || pc_a !== 9'h080)
                    begin errors++; $display("FAIL b2b_first: got v=%b pc=%h exp v=1 pc=080", valid_a, pc_a); end
            end
        end
        checks++; if (saw40 !== 1'b0) begin errors++; $display("FAIL b2b_no40: got %b exp 0", saw40); end
    endtask

    task automatic test_pc_wrap();
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            if (k == 1) begin
                checks++; if (addr_b !== 9'h1FC) begin errors++; $display("FAIL wrap_addr1: got %h exp 1fc", addr_b); end
            end
            if (k == 2) begin
                checks++; if (addr_b !== 9'h000) begin errors++; $display("FAIL wrap_addr2: got %h exp 000", addr_b); end
            end
            if (k == LAT) begin
                checks++; if (valid_b !== 1'b1 || pc_b !== 9'h1FC) begin errors++; $display("FAIL wrap_pc0: got v=%b pc=%h exp 1fc", valid_b, pc_b); end
            end
            if (k == LAT + 1) begin
                checks++; if (pc_b !== 9'h000) begin errors++; $display("FAIL wrap_pc1: got %h exp 000", pc_b); end
            end
            if (k == LAT + 2) begin
                checks++; if (pc_b !== 9'h004) begin errors++; $display("FAIL wrap_pc2: got %h exp 004", pc_b); end
            end
        end
    endtask

    task automatic test_halt_drain();
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) cyc();
        cyc(); halt = 1'b1; #1;
        checks++; if (req_a !== 1'b0 || occ_a !== 3'd1) begin errors++; $display("FAIL halt_c3: got req=%b occ=%0d exp 0/1", req_a, occ_a); end
        cyc(); if_ready = 1'b1; #1;
        checks++; if (req_a !== 1'b0 || occ_a !== 3'd2 || pc_a !== 9'h000)
            begin errors++; $display("FAIL halt_c4: got req=%b occ=%0d pc=%h exp 0/2/000", req_a, occ_a, pc_a); end
        cyc(); #1;
        checks++; if (req_a !== 1'b0 || valid_a !== 1'b1 || pc_a !== 9'h004)
            begin errors++; $display("FAIL halt_c5: got req=%b v=%b pc=%h exp 0/1/004", req_a, valid_a, pc_a); end
        cyc(); #1;
        checks++; if (req_a !== 1'b0 || valid_a !== 1'b0 || occ_a !== 3'd0)
            begin errors++; $display("FAIL halt_c6: got req=%b v=%b occ=%0d exp 0/0/0", req_a, valid_a, occ_a); end
        cyc(); #1;
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL halt_c7: got %b exp 0", req_a); end
        cyc(); halt = 1'b0; #1;
        checks++; if (req_a !== 1'b1 || addr_a !== 9'h008) begin errors++; $display("FAIL halt_resume: got req=%b addr=%h exp 1/008", req_a, addr_a); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_fill();
        test_redirect_flush();
        test_back_to_back_redirect();
        test_pc_wrap();
        test_halt_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
